// File: rtl/pipe_ctrl_if.sv
// Hazard inputs from the datapath and stall/flush controls back to the
// pipeline registers, bundled between the core datapath and pipe_ctrl.
interface pipe_ctrl_if;
  logic [4:0] id_rs1;
  logic [4:0] id_rs2;
  logic       id_rs1_used;
  logic       id_rs2_used;
  logic [4:0] ex_rd;
  logic       ex_is_load;
  logic       ex_reg_write;
  logic       ex_redirect;
  logic       ex_md_start;
  logic       mem_req_valid;
  logic       mem_ready;
  logic       trap;

  logic       pc_stall;
  logic       stall_if_id;
  logic       stall_id_ex;
  logic       stall_ex_mem;
  logic       flush_if_id;
  logic       flush_id_ex;
  logic       flush_ex_mem;
  logic       flush_mem_wb;
  logic       md_busy;
  logic       mem_timeout;

  // Datapath side: reports hazards, obeys stall/flush.
  modport master (
    output id_rs1, id_rs2, id_rs1_used, id_rs2_used, ex_rd, ex_is_load,
           ex_reg_write, ex_redirect, ex_md_start, mem_req_valid, mem_ready, trap,
    input  pc_stall, stall_if_id, stall_id_ex, stall_ex_mem, flush_if_id,
           flush_id_ex, flush_ex_mem, flush_mem_wb, md_busy, mem_timeout
  );

  // Controller side.
  modport slave (
    input  id_rs1, id_rs2, id_rs1_used, id_rs2_used, ex_rd, ex_is_load,
           ex_reg_write, ex_redirect, ex_md_start, mem_req_valid, mem_ready, trap,
    output pc_stall, stall_if_id, stall_id_ex, stall_ex_mem, flush_if_id,
           flush_id_ex, flush_ex_mem, flush_mem_wb, md_busy, mem_timeout
  );
endinterface

// File: rtl/pipe_ctrl.sv
// Stall/flush controller for the five-stage pipeline: fixed-priority hazard
// resolution plus the mul/div occupancy FSM and memory wait watchdog.
module pipe_ctrl #(
  parameter int unsigned MD_LATENCY  = 34,
  parameter int unsigned MEM_TIMEOUT = 255
) (
  input logic        clk,
  input logic        rst_n,
  pipe_ctrl_if.slave bus
);

  localparam int unsigned MD_W  = (MD_LATENCY > 2) ? $clog2(MD_LATENCY) : 1;
  localparam int unsigned MEM_W = $clog2(MEM_TIMEOUT + 1);

  typedef enum logic {RUN = 1'b0, MD_BUSY = 1'b1} state_e;

  state_e             state_q, state_d;
  logic [MD_W-1:0]    md_cnt_q, md_cnt_d;
  logic [MEM_W-1:0]   mem_cnt_q, mem_cnt_d;

  logic mem_wait, load_use, md_hold, in_md, cnt_hit;
  logic pc_stall, stall_if_id, stall_id_ex, stall_ex_mem;
  logic flush_if_id, flush_id_ex, flush_ex_mem, flush_mem_wb;
  logic md_busy, mem_timeout;

  always_comb begin
    mem_wait = bus.mem_req_valid & ~bus.mem_ready;
    in_md    = (state_q == MD_BUSY);
    md_hold  = (~in_md & bus.ex_md_start) | (in_md & (md_cnt_q != '0));
    cnt_hit  = mem_wait & (mem_cnt_q == MEM_W'(MEM_TIMEOUT - 1));
    load_use = bus.ex_is_load & bus.ex_reg_write & (bus.ex_rd != 5'd0) &
               ((bus.id_rs1_used & (bus.id_rs1 == bus.ex_rd)) |
                (bus.id_rs2_used & (bus.id_rs2 == bus.ex_rd)));
  end

  // Next-state: the divider keeps counting through memory waits, but release
  // waits until the wait ends so the instruction is not lost.
  always_comb begin
    state_d   = state_q;
    md_cnt_d  = md_cnt_q;
    mem_cnt_d = mem_cnt_q;
    if (bus.trap) begin
      state_d   = RUN;
      md_cnt_d  = '0;
      mem_cnt_d = '0;
    end else begin
      if (!mem_wait || cnt_hit) mem_cnt_d = '0;
      else                      mem_cnt_d = mem_cnt_q + MEM_W'(1);

      if (!in_md) begin
        if (bus.ex_md_start && !mem_wait) begin
          state_d  = MD_BUSY;
          md_cnt_d = MD_W'(MD_LATENCY - 2);
        end
      end else if (md_cnt_q != '0) begin
        md_cnt_d = md_cnt_q - MD_W'(1);
      end else if (!mem_wait) begin
        state_d = RUN;
      end
    end
  end

  // Fixed-priority outputs; reset forces the pipeline full of bubbles.
  always_comb begin
    pc_stall     = 1'b0;
    stall_if_id  = 1'b0;
    stall_id_ex  = 1'b0;
    stall_ex_mem = 1'b0;
    flush_if_id  = 1'b0;
    flush_id_ex  = 1'b0;
    flush_ex_mem = 1'b0;
    flush_mem_wb = 1'b0;
    md_busy      = rst_n & in_md;
    mem_timeout  = rst_n & ~bus.trap & cnt_hit;
    if (!rst_n || bus.trap) begin
      flush_if_id  = 1'b1;
      flush_id_ex  = 1'b1;
      flush_ex_mem = 1'b1;
      flush_mem_wb = 1'b1;
    end else if (mem_wait) begin
      pc_stall     = 1'b1;
      stall_if_id  = 1'b1;
      stall_id_ex  = 1'b1;
      stall_ex_mem = 1'b1;
      flush_mem_wb = 1'b1;
    end else if (md_hold) begin
      pc_stall     = 1'b1;
      stall_if_id  = 1'b1;
      stall_id_ex  = 1'b1;
      flush_ex_mem = 1'b1;
    end else if (bus.ex_redirect) begin
      flush_if_id  = 1'b1;
      flush_id_ex  = 1'b1;
    end else if (load_use) begin
      pc_stall     = 1'b1;
      stall_if_id  = 1'b1;
      flush_id_ex  = 1'b1;
    end
  end

  assign bus.pc_stall     = pc_stall;
  assign bus.stall_if_id  = stall_if_id;
  assign bus.stall_id_ex  = stall_id_ex;
  assign bus.stall_ex_mem = stall_ex_mem;
  assign bus.flush_if_id  = flush_if_id;
  assign bus.flush_id_ex  = flush_id_ex;
  assign bus.flush_ex_mem = flush_ex_mem;
  assign bus.flush_mem_wb = flush_mem_wb;
  assign bus.md_busy      = md_busy;
  assign bus.mem_timeout  = mem_timeout;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= RUN;
      md_cnt_q  <= '0;
      mem_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      md_cnt_q  <= md_cnt_d;
      mem_cnt_q <= mem_cnt_d;
    end
  end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl with MD_LATENCY=4, MEM_TIMEOUT=3.
module tb_pipe_ctrl;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  pipe_ctrl_if bus();

  pipe_ctrl #(.MD_LATENCY(4), .MEM_TIMEOUT(3)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  // {pc_stall, stall_if_id, stall_id_ex, stall_ex_mem,
  //  flush_if_id, flush_id_ex, flush_ex_mem, flush_mem_wb, md_busy, mem_timeout}
  logic [9:0] outv;
  assign outv = {bus.pc_stall, bus.stall_if_id, bus.stall_id_ex, bus.stall_ex_mem,
                 bus.flush_if_id, bus.flush_id_ex, bus.flush_ex_mem, bus.flush_mem_wb,
                 bus.md_busy, bus.mem_timeout};

  localparam logic [9:0] NONE  = 10'b0000_0000_00;
  localparam logic [9:0] FLALL = 10'b0000_1111_00;
  localparam logic [9:0] MEMW  = 10'b1111_0001_00;
  localparam logic [9:0] MDH   = 10'b1110_0010_00;
  localparam logic [9:0] REDIR = 10'b0000_1100_00;
  localparam logic [9:0] LDU   = 10'b1100_0100_00;
  localparam logic [9:0] BUSY  = 10'b0000_0000_10;
  localparam logic [9:0] TMO   = 10'b0000_0000_01;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [9:0] got, input logic [9:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%b exp=%b", tag, got, exp);
    end
  endtask

  // Inputs are already applied; settle, compare, then advance one clock.
  task automatic step(input string tag, input logic [9:0] exp);
    #2;
    check(tag, outv, exp);
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus.id_rs1 = 5'd0;        bus.id_rs2 = 5'd0;
    bus.id_rs1_used = 1'b0;   bus.id_rs2_used = 1'b0;
    bus.ex_rd = 5'd0;         bus.ex_is_load = 1'b0;
    bus.ex_reg_write = 1'b0;  bus.ex_redirect = 1'b0;
    bus.ex_md_start = 1'b0;   bus.mem_req_valid = 1'b0;
    bus.mem_ready = 1'b0;     bus.trap = 1'b0;
  endtask

  task automatic set_load_use(input logic [4:0] rd);
    bus.ex_is_load = 1'b1; bus.ex_reg_write = 1'b1; bus.ex_rd = rd;
    bus.id_rs1 = 5'd5; bus.id_rs1_used = 1'b1;
    bus.id_rs2 = 5'd1; bus.id_rs2_used = 1'b1;
  endtask

  initial begin
    clear_inputs();
    rst_n = 1'b0;
    bus.trap = 1'b1;
    bus.ex_md_start = 1'b1;
    @(posedge clk); #1;
    step("rst_over_trap", FLALL);
    step("rst_hold", FLALL);
    clear_inputs();
    rst_n = 1'b1;
    step("idle", NONE);

    // Load-use: lw x5 in EX, add x6,x5,x1 in ID
    set_load_use(5'd5);
    step("ldu", LDU);
    bus.ex_is_load = 1'b0; bus.ex_reg_write = 1'b0; bus.ex_rd = 5'd0;
    step("ldu_after", NONE);
    set_load_use(5'd0);
    bus.id_rs1 = 5'd0;
    step("ldu_x0", NONE);
    set_load_use(5'd5);
    bus.id_rs1 = 5'd3;   bus.id_rs2 = 5'd5;
    step("ldu_rs2", LDU);
    bus.id_rs2_used = 1'b0;
    step("ldu_unused", NONE);

    // Redirect beats load-use
    clear_inputs();
    set_load_use(5'd5);
    bus.ex_redirect = 1'b1;
    step("redir_ldu", REDIR);
    clear_inputs();
    step("redir_after", NONE);

    // Mul/div window, then back-to-back second op
    bus.ex_md_start = 1'b1;
    step("md_c0", MDH);
    step("md_c1", MDH | BUSY);
    step("md_c2", MDH | BUSY);
    step("md_rel", BUSY);
    step("md2_c0", MDH);
    step("md2_c1", MDH | BUSY);
    step("md2_c2", MDH | BUSY);
    step("md2_rel", BUSY);
    bus.ex_md_start = 1'b0;
    step("md_done", NONE);

    // Mul/div overlapped by a 5-cycle memory wait
    bus.ex_md_start = 1'b1;
    step("mdw_c0", MDH);
    bus.mem_req_valid = 1'b1;
    step("mdw_c1", MEMW | BUSY);
    step("mdw_c2", MEMW | BUSY);
    step("mdw_c3", MEMW | BUSY | TMO);
    step("mdw_c4", MEMW | BUSY);
    step("mdw_c5", MEMW | BUSY);
    bus.mem_ready = 1'b1;
    step("mdw_rel", BUSY);
    clear_inputs();
    step("mdw_done", NONE);

    // Watchdog: 7 wait cycles, pulses on wait cycles 3 and 6
    bus.mem_req_valid = 1'b1;
    step("to_1", MEMW);
    step("to_2", MEMW);
    step("to_3", MEMW | TMO);
    step("to_4", MEMW);
    step("to_5", MEMW);
    step("to_6", MEMW | TMO);
    step("to_7", MEMW);
    bus.mem_ready = 1'b1;
    step("to_ready", NONE);
    clear_inputs();

    // Memory wait masks redirect and a new mul/div start
    bus.mem_req_valid = 1'b1; bus.ex_redirect = 1'b1; bus.ex_md_start = 1'b1;
    step("memw_mask", MEMW);
    clear_inputs();
    step("memw_no_md", NONE);

    // Trap during MD_BUSY with a memory wait
    bus.ex_md_start = 1'b1;
    step("trap_md_c0", MDH);
    bus.mem_req_valid = 1'b1; bus.trap = 1'b1;
    #2;
    check("trap_flush", outv & ~BUSY, FLALL);
    @(posedge clk); #1;
    clear_inputs();
    step("trap_after", NONE);

    // Reset asserted mid mul/div
    bus.ex_md_start = 1'b1;
    step("rmd_c0", MDH);
    bus.ex_md_start = 1'b0;
    step("rmd_c1", MDH | BUSY);
    rst_n = 1'b0;
    step("rmd_rst", FLALL);
    rst_n = 1'b1;
    step("rmd_after", NONE);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
